// File: rtl/apb_equivalence_monitor.sv
// apb_equivalence_monitor
//   Snoops one shared APB request bus that fans out to NUM_DUTS DUT copies,
//   captures every DUT's PRDATA when that DUT raises PREADY, and compares all
//   captures against DUT 0 once every DUT has responded.  Flags are meant to
//   be used as assertion / cover targets in an equivalence bench.
//
// Optional feature macro: APB_EQ_PSLVERR_CHECK_EN
//   Defined  : adds PSLVERR[NUM_DUTS]; PSLVERR is captured with PRDATA and
//              compared on reads and writes (PRDATA excluded on writes).
//   Undefined: no PSLVERR port; writes are never compared or counted.
//
// Ports
//   PCLK, PRESETn        clock, asynchronous active-low reset
//   PSEL/PENABLE/PWRITE  shared APB control
//   PADDR[ADDR_W]        shared address
//   PREADY[NUM_DUTS]     per-DUT ready
//   PRDATA[NUM_DUTS*DATA_W] per-DUT read data, DUT i at [i*DATA_W +: DATA_W]
//   mismatch             one-cycle pulse on a failed compare
//   mismatch_sticky      set on first mismatch, held until reset
//   first_addr/first_mask address and per-DUT diff of the first mismatch
//   read_count/mismatch_count saturating counters
//   timeout              sticky, ACCESS ran TIMEOUT cycles without all ready
//   protocol_error       sticky, illegal APB phase sequence
module apb_equivalence_monitor #(
    parameter int NUM_DUTS = 2,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 12,
    parameter int CNT_W    = 16,
    parameter int TIMEOUT  = 64
) (
    input  logic                       PCLK,
    input  logic                       PRESETn,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [ADDR_W-1:0]          PADDR,
    input  logic [NUM_DUTS-1:0]        PREADY,
    input  logic [NUM_DUTS*DATA_W-1:0] PRDATA,
`ifdef APB_EQ_PSLVERR_CHECK_EN
    input  logic [NUM_DUTS-1:0]        PSLVERR,
`endif
    output logic                       mismatch,
    output logic                       mismatch_sticky,
    output logic [ADDR_W-1:0]          first_addr,
    output logic [NUM_DUTS-1:0]        first_mask,
    output logic [CNT_W-1:0]           read_count,
    output logic [CNT_W-1:0]           mismatch_count,
    output logic                       timeout,
    output logic                       protocol_error
);

    localparam int            TW   = $clog2(TIMEOUT + 1) + 1;
    localparam logic [TW-1:0] TO_V = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, COMPARE} state_e;

    state_e                           state_q, state_d;
    logic [ADDR_W-1:0]                addr_q, addr_d;
    logic                             write_q, write_d;
    logic [TW-1:0]                    cnt_q, cnt_d;
    logic [NUM_DUTS-1:0]              valid_q, valid_d;
    logic [NUM_DUTS-1:0][DATA_W-1:0]  cap_q, cap_d;
`ifdef APB_EQ_PSLVERR_CHECK_EN
    logic [NUM_DUTS-1:0]              err_q, err_d;
`endif
    logic                             sticky_q, sticky_d;
    logic [ADDR_W-1:0]                faddr_q, faddr_d;
    logic [NUM_DUTS-1:0]              fmask_q, fmask_d;
    logic [CNT_W-1:0]                 rcnt_q, rcnt_d;
    logic [CNT_W-1:0]                 mcnt_q, mcnt_d;
    logic                             to_q, to_d;
    logic                             pe_q, pe_d;

    logic                setup_ph, access_ph, in_access, bus_ok, all_valid;
    logic                timeout_now, mis_now, cmp_this;
    logic [TW-1:0]       cnt_cur;
    logic [NUM_DUTS-1:0] valid_nxt, diff;

    assign setup_ph  = PSEL & ~PENABLE;
    assign access_ph = PSEL & PENABLE;

    // The state register lags the bus by one cycle: while in SETUP, a cycle
    // with PSEL&PENABLE is already the first access cycle, so it is handled
    // exactly like ACCESS (count 1).  This keeps zero-wait transfers visible.
    assign in_access = (state_q == ACCESS) || (state_q == SETUP && access_ph);
    assign cnt_cur   = (state_q == ACCESS) ? cnt_q : TW'(1);
    assign bus_ok    = access_ph && (PADDR == addr_q) && (PWRITE == write_q);
    assign valid_nxt = valid_q | PREADY;
    assign all_valid = &valid_nxt;

`ifdef APB_EQ_PSLVERR_CHECK_EN
    assign cmp_this = 1'b1;
`else
    assign cmp_this = ~write_q;
`endif

    always_comb begin
        diff = '0;
        for (int i = 1; i < NUM_DUTS; i++) begin
`ifdef APB_EQ_PSLVERR_CHECK_EN
            diff[i] = (~write_q && (cap_q[i] != cap_q[0])) || (err_q[i] != err_q[0]);
`else
            diff[i] = (cap_q[i] != cap_q[0]);
`endif
        end
    end

    assign mis_now     = (state_q == COMPARE) && (|diff);
    assign timeout_now = in_access && bus_ok && !all_valid && (cnt_cur == TO_V);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        write_d  = write_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        cap_d    = cap_q;
`ifdef APB_EQ_PSLVERR_CHECK_EN
        err_d    = err_q;
`endif
        sticky_d = sticky_q;
        faddr_d  = faddr_q;
        fmask_d  = fmask_q;
        rcnt_d   = rcnt_q;
        mcnt_d   = mcnt_q;
        to_d     = to_q;
        pe_d     = pe_q;

        case (state_q)
            IDLE: begin
                if (setup_ph) begin
                    state_d = SETUP;
                    addr_d  = PADDR;
                    write_d = PWRITE;
                    valid_d = '0;
                end else if (access_ph) begin
                    pe_d = 1'b1;
                end
            end
            SETUP: begin
                if (!access_ph) begin
                    if (setup_ph) begin
                        addr_d  = PADDR;
                        write_d = PWRITE;
                        valid_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            COMPARE: begin
                rcnt_d = (&rcnt_q) ? rcnt_q : rcnt_q + 1'b1;
                if (|diff) begin
                    mcnt_d = (&mcnt_q) ? mcnt_q : mcnt_q + 1'b1;
                    if (!sticky_q) begin
                        sticky_d = 1'b1;
                        faddr_d  = addr_q;
                        fmask_d  = diff;
                    end
                end
                if (setup_ph) begin
                    state_d = SETUP;
                    addr_d  = PADDR;
                    write_d = PWRITE;
                    valid_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        if (in_access) begin
            if (!bus_ok) begin
                pe_d    = 1'b1;
                state_d = IDLE;
            end else begin
                // first PREADY per DUT wins; later pulses are ignored
                for (int i = 0; i < NUM_DUTS; i++) begin
                    if (PREADY[i] && !valid_q[i]) begin
                        cap_d[i] = PRDATA[i*DATA_W +: DATA_W];
`ifdef APB_EQ_PSLVERR_CHECK_EN
                        err_d[i] = PSLVERR[i];
`endif
                    end
                end
                valid_d = valid_nxt;
                if (all_valid) begin
                    state_d = cmp_this ? COMPARE : IDLE;
                end else if (cnt_cur == TO_V) begin
                    to_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = ACCESS;
                    cnt_d   = cnt_cur + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            cnt_q    <= '0;
            valid_q  <= '0;
            cap_q    <= '0;
`ifdef APB_EQ_PSLVERR_CHECK_EN
            err_q    <= '0;
`endif
            sticky_q <= 1'b0;
            faddr_q  <= '0;
            fmask_q  <= '0;
            rcnt_q   <= '0;
            mcnt_q   <= '0;
            to_q     <= 1'b0;
            pe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            cap_q    <= cap_d;
`ifdef APB_EQ_PSLVERR_CHECK_EN
            err_q    <= err_d;
`endif
            sticky_q <= sticky_d;
            faddr_q  <= faddr_d;
            fmask_q  <= fmask_d;
            rcnt_q   <= rcnt_d;
            mcnt_q   <= mcnt_d;
            to_q     <= to_d;
            pe_q     <= pe_d;
        end
    end

    assign mismatch        = mis_now;
    assign mismatch_sticky = sticky_q;
    assign first_addr      = faddr_q;
    assign first_mask      = fmask_q;
    assign read_count      = rcnt_q;
    assign mismatch_count  = mcnt_q;
    // raised in the access cycle that hits the limit, then held
    assign timeout         = to_q | timeout_now;
    assign protocol_error  = pe_q;

endmodule

// File: tb/tb_apb_equivalence_monitor.sv
// Scoreboard bench for apb_equivalence_monitor (3 DUTs, TIMEOUT=6, 3-bit
// counters so saturation is reachable).  Stimulus pushes the expected
// compare outcome; a negedge monitor pops and checks it.
module tb_apb_equivalence_monitor;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 12;
    localparam int CW = 3;
    localparam int TO = 6;

    logic            PCLK, PRESETn, PSEL, PENABLE, PWRITE;
    logic [AW-1:0]   PADDR;
    logic [N-1:0]    PREADY;
    logic [N*DW-1:0] PRDATA;
    logic            mismatch, mismatch_sticky, timeout, protocol_error;
    logic [AW-1:0]   first_addr;
    logic [N-1:0]    first_mask;
    logic [CW-1:0]   read_count, mismatch_count;

    apb_equivalence_monitor #(
        .NUM_DUTS(N), .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW), .TIMEOUT(TO)
    ) u_dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PREADY(PREADY), .PRDATA(PRDATA),
        .mismatch(mismatch), .mismatch_sticky(mismatch_sticky),
        .first_addr(first_addr), .first_mask(first_mask),
        .read_count(read_count), .mismatch_count(mismatch_count),
        .timeout(timeout), .protocol_error(protocol_error)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        int            due;
        logic          mis;
        logic [CW-1:0] rc, mc;
        logic          st;
        logic [AW-1:0] fa;
        logic [N-1:0]  fm;
    } sb_t;
    sb_t q[$];

    logic [CW-1:0] exp_rc, exp_mc;
    logic          exp_st;
    logic [AW-1:0] exp_fa;
    logic [N-1:0]  exp_fm;

    function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    task automatic model_reset();
        exp_rc = '0; exp_mc = '0; exp_st = 1'b0; exp_fa = '0; exp_fm = '0;
    endtask

    // monitor: compare pulse in the cycle after the last ready, counters the cycle after
    always @(negedge PCLK) begin
        if (q.size() != 0 && cyc == q[0].due)
            chk("cmp_pulse", mismatch, q[0].mis);
        else if (mismatch !== 1'b0)
            chk("stray_mismatch", mismatch, 0);
        if (q.size() != 0 && cyc == q[0].due + 1) begin
            chk("read_count",     read_count,      q[0].rc);
            chk("mismatch_count", mismatch_count,  q[0].mc);
            chk("sticky",         mismatch_sticky, q[0].st);
            chk("first_addr",     first_addr,      q[0].fa);
            chk("first_mask",     first_mask,      q[0].fm);
            void'(q.pop_front());
        end
    end

    task automatic bus_idle();
        PSEL = 0; PENABLE = 0; PWRITE = 0; PREADY = '0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mismatch"}, mismatch, 0);
        chk({tag, "_sticky"},   mismatch_sticky, 0);
        chk({tag, "_faddr"},    first_addr, 0);
        chk({tag, "_fmask"},    first_mask, 0);
        chk({tag, "_rcnt"},     read_count, 0);
        chk({tag, "_mcnt"},     mismatch_count, 0);
        chk({tag, "_timeout"},  timeout, 0);
        chk({tag, "_perr"},     protocol_error, 0);
    endtask

    // One transfer; DUT i raises PREADY at access cycle l_i and holds it, with
    // different data afterwards so only the first capture may count.
    // m is the hand-computed diff mask expected for a read.
    task automatic xfer(input logic [AW-1:0] a, input logic wr,
                        input logic [31:0] d0, d1, d2,
                        input int l0, l1, l2, input logic [N-1:0] m);
        logic [N-1:0][31:0] d;
        int lat[3];
        int last_k;
        sb_t e;
        d[0] = d0; d[1] = d1; d[2] = d2;
        lat[0] = l0; lat[1] = l1; lat[2] = l2;
        last_k = l0;
        if (l1 > last_k) last_k = l1;
        if (l2 > last_k) last_k = l2;
        @(posedge PCLK); #1;
        PSEL = 1; PENABLE = 0; PADDR = a; PWRITE = wr; PREADY = '0; PRDATA = '0;
        for (int k = 1; k <= last_k; k++) begin
            @(posedge PCLK); #1;
            PENABLE = 1;
            for (int i = 0; i < N; i++) begin
                PREADY[i] = (k >= lat[i]);
                if (k == lat[i])     PRDATA[i*DW +: DW] = d[i];
                else if (k > lat[i]) PRDATA[i*DW +: DW] = ~d[i];
                else                 PRDATA[i*DW +: DW] = 32'hDEAD_0000 + 32'(i);
            end
        end
        if (!wr) begin
            exp_rc = sat(exp_rc);
            if (m != '0) begin
                exp_mc = sat(exp_mc);
                if (!exp_st) begin exp_st = 1'b1; exp_fa = a; exp_fm = m; end
            end
            e.due = cyc + 1; e.mis = (m != '0);
            e.rc = exp_rc; e.mc = exp_mc; e.st = exp_st; e.fa = exp_fa; e.fm = exp_fm;
            q.push_back(e);
        end
        @(posedge PCLK); #1;
        bus_idle();
    endtask

    initial begin
        PRESETn = 0; PADDR = '0; PRDATA = '0;
        bus_idle();
        model_reset();
        repeat (3) @(posedge PCLK);
        #1 check_all_zero("reset");
        PRESETn = 1;

        // clean read, all ready together
        xfer(12'h010, 0, 32'hA5A5_0000, 32'hA5A5_0000, 32'hA5A5_0000, 1, 1, 1, 3'b000);
        // DUT1 differs
        xfer(12'h020, 0, 32'h1, 32'h2, 32'h1, 1, 1, 1, 3'b010);
        // second mismatch: first record must hold
        xfer(12'h030, 0, 32'h5, 32'h5, 32'h7, 2, 1, 1, 3'b100);
        // DUT2 five cycles late, last ready exactly at the TIMEOUT-th access cycle
        xfer(12'h040, 0, 32'h77, 32'h77, 32'h77, 1, 1, 6, 3'b000);
        @(negedge PCLK);
        chk("no_timeout_at_limit", timeout, 0);
        // write: never compared
        xfer(12'h050, 1, 32'h1, 32'h2, 32'h3, 1, 1, 1, 3'b000);
        @(posedge PCLK); @(negedge PCLK);
        chk("rc_after_write", read_count, exp_rc);
        chk("mc_after_write", mismatch_count, exp_mc);
        // counters saturate at 7
        for (int j = 0; j < 6; j++)
            xfer(12'h060 + 12'(j*4), 0, 32'h10, 32'h10, 32'h11, 1, 2, 1, 3'b100);
        @(posedge PCLK); @(negedge PCLK);
        chk("rc_saturated", read_count, 3'd7);
        chk("mc_saturated", mismatch_count, 3'd7);
        chk("perr_before", protocol_error, 0);

        // PADDR change mid-ACCESS
        @(posedge PCLK); #1;
        PSEL = 1; PENABLE = 0; PADDR = 12'h070; PWRITE = 0;
        @(posedge PCLK); #1;
        PENABLE = 1; PREADY = 3'b001; PRDATA = {32'h3, 32'h2, 32'h1};
        @(posedge PCLK); #1;
        PADDR = 12'h074; PREADY = 3'b001;
        @(posedge PCLK); #1;
        bus_idle();
        @(negedge PCLK);
        chk("perr_addr_change", protocol_error, 1);
        chk("rc_after_perr", read_count, exp_rc);

        // reset in the middle of ACCESS
        @(posedge PCLK); #1;
        PSEL = 1; PENABLE = 0; PADDR = 12'h080; PWRITE = 0;
        @(posedge PCLK); #1;
        PENABLE = 1; PREADY = 3'b011;
        @(posedge PCLK); #1;
        #2 PRESETn = 0;
        #1 check_all_zero("rst_mid");
        @(posedge PCLK); #1;
        bus_idle();
        @(posedge PCLK); #1;
        PRESETn = 1;
        model_reset();
        xfer(12'h090, 0, 32'h1234, 32'h1234, 32'h1234, 2, 2, 2, 3'b000);
        xfer(12'h0A0, 0, 32'h9, 32'h9, 32'h8, 1, 1, 1, 3'b100);

        // PSEL&PENABLE straight from IDLE
        @(posedge PCLK); #1;
        PSEL = 1; PENABLE = 1; PADDR = 12'h0;
        @(posedge PCLK); #1;
        bus_idle();
        @(negedge PCLK);
        chk("perr_no_setup", protocol_error, 1);

        // DUT1 never ready: timeout in the TIMEOUT-th access cycle
        @(posedge PCLK); #1;
        PSEL = 1; PENABLE = 0; PADDR = 12'h0B0; PWRITE = 0;
        for (int k = 1; k <= TO; k++) begin
            @(posedge PCLK); #1;
            PENABLE = 1; PREADY = 3'b101; PRDATA = {32'h3, 32'h2, 32'h1};
            @(negedge PCLK);
            if (k == TO - 1) chk("timeout_early", timeout, 0);
            if (k == TO)     chk("timeout_at_limit", timeout, 1);
        end
        @(posedge PCLK); #1;
        bus_idle();
        @(negedge PCLK);
        chk("timeout_sticky", timeout, 1);
        chk("rc_after_timeout", read_count, exp_rc);

        for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge PCLK);
        repeat (2) @(posedge PCLK);
        chk("scoreboard_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
